// File: rtl/mem_dump_pkg.sv
// ============================================================================
// mem_dump_pkg : shared FSM encoding and defaults for mem_dump_reader
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mem_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam int unsigned DFLT_ADDR_STEP = 4;

endpackage

`default_nettype wire

// File: rtl/mem_dump_reader.sv
// ============================================================================
// mem_dump_reader : drains a word range of data memory over valid/ready
// Optional feature: MEM_DUMP_CHECKSUM_EN adds a running sum of dumped words
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_STEP = DFLT_ADDR_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
`ifdef MEM_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              accept;

  assign accept = (state_q == ST_PRESENT) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            // masking keeps the latched address word aligned
            addr_d  = start_addr & ~ADDR_W'(3);
            cnt_d   = word_count;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        out_data_d = mem_rdata;
        out_addr_d = addr_q;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          cnt_d   = cnt_q - CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(ADDR_STEP);
          state_d = (cnt_q == CNT_W'(1)) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == ST_ISSUE);
    mem_addr  = (state_q == ST_ISSUE) ? addr_q : '0;
    out_valid = (state_q == ST_PRESENT);
    busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_PRESENT);
    done      = (state_q == ST_FINISH);
    out_data  = out_data_q;
    out_addr  = out_addr_q;
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if ((state_q == ST_IDLE) && start) begin
      cksum_d = '0;
    end else if (accept) begin
      cksum_d = cksum_q + out_data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign checksum = cksum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: directed table plus randomized dumps
// compared against an address/data list model of the dump.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        busy;
  logic        done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mem_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
`ifdef MEM_DUMP_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // memory model: explicit preloads, otherwise an address-derived pattern
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rdata <= memval(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  logic [31:0] beat_a[$];
  logic [31:0] beat_d[$];
  int          beat_c[$];
  int          done_cyc[$];
  int          rd_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] held_d, held_a;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data !== held_d || out_addr !== held_a) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h a=%h expected v=1 d=%h a=%h", out_valid, out_data, out_addr, held_d, held_a);
        end
      end
      if (mem_rd_en) rd_cnt++;
      if (done) done_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        beat_a.push_back(out_addr);
        beat_d.push_back(out_data);
        beat_c.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_a = out_addr;
    end
  end

  // ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall on beat 2
  int ready_mode = 0;
  int stall_left = 0;
  bit stall_done = 0;

  always @(posedge clk) begin
    #2;
    if (ready_mode == 2 && !stall_done && out_valid && beat_a.size() == 1) begin
      stall_left = 5;
      stall_done = 1;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 1) begin
      out_ready = ($urandom_range(0, 2) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic clear_mon();
    beat_a.delete();
    beat_d.delete();
    beat_c.delete();
    done_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_addr"},  out_addr, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk({tag, "_checksum"},  checksum, 0);
`endif
  endtask

  task automatic run_dump(input logic [31:0] sa, input int cnt, input int mode,
                          input bit ign, input logic [31:0] exp_last);
    int          s;
    int          budget;
    logic [31:0] sa_al;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [31:0] sum;
    clear_mon();
    ready_mode = mode;
    stall_done = 0;
    @(posedge clk); #2;
    start = 1'b1; start_addr = sa; word_count = 16'(cnt); s = cyc;
    @(posedge clk); #2;
    start = 1'b0; start_addr = $urandom; word_count = 16'($urandom);
    chk("busy_after_start", busy, (cnt != 0));
    if (ign) begin
      @(posedge clk); #2;
      start = 1'b1; start_addr = 32'h500; word_count = 16'd5;
      @(posedge clk); #2;
      start = 1'b0;
    end
    budget = 40 + cnt * 12;
    while (done_cyc.size() == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("done_seen", (done_cyc.size() != 0), 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("beat_count", beat_a.size(), cnt);
    chk("rd_en_count", rd_cnt, cnt);
    sa_al = sa & ~32'h3;
    sum = '0;
    for (int i = 0; i < cnt; i++) begin
      ea = sa_al + 32'(i * 4);
      ed = memval(ea);
      sum += ed;
      if (i < beat_a.size()) begin
        chk("beat_addr", beat_a[i], ea);
        chk("beat_data", beat_d[i], ed);
        if (mode == 0) chk("beat_cycle", beat_c[i] - s, 3 * (i + 1));
      end
    end
    if (mode == 0 && done_cyc.size() != 0)
      chk("done_cycle", done_cyc[0] - s, (cnt == 0) ? 1 : 3 * cnt + 1);
    if (cnt > 0 && beat_a.size() == cnt) chk("last_addr", beat_a[cnt-1], exp_last);
`ifdef MEM_DUMP_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
  endtask

  typedef struct {
    logic [31:0] sa;
    int          cnt;
    int          mode;
    bit          ign;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int          nv;
    int          budget;
    int          rc;
    logic [31:0] rs;

    vecs[0] = '{sa: 32'h0,         cnt: 4, mode: 0, ign: 1'b0, exp_last: 32'hC};
    vecs[1] = '{sa: 32'h0,         cnt: 4, mode: 2, ign: 1'b0, exp_last: 32'hC};
    vecs[2] = '{sa: 32'h0,         cnt: 0, mode: 0, ign: 1'b0, exp_last: 32'h0};
    vecs[3] = '{sa: 32'hFFFF_FFFC, cnt: 2, mode: 0, ign: 1'b1, exp_last: 32'h0};

    mem[32'h0] = 32'h11;
    mem[32'h4] = 32'h22;
    mem[32'h8] = 32'h33;
    mem[32'hC] = 32'h44;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // reset while word 3 is presented
    clear_mon();
    ready_mode = 0;
    @(posedge clk); #2;
    start = 1'b1; start_addr = 32'h100; word_count = 16'd8;
    @(posedge clk); #2;
    start = 1'b0;
    nv = 0;
    budget = 40;
    while (nv < 3 && budget > 0) begin
      @(negedge clk);
      if (out_valid) nv++;
      budget--;
    end
    chk("reached_word3", nv, 3);
    #1 reset = 1'b1;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    run_dump(32'h100, 2, 0, 1'b0, 32'h104);

    foreach (vecs[i]) run_dump(vecs[i].sa, vecs[i].cnt, vecs[i].mode, vecs[i].ign, vecs[i].exp_last);

    for (int k = 0; k < 8; k++) begin
      rs = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rc = $urandom_range(0, 6);
      run_dump(rs, rc, $urandom_range(0, 1), 1'b0, (rs & ~32'h3) + 32'((rc - 1) * 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
